pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register; the next generation of the fixed-field stage registers between IF/ID/EX/MEM/WB.
- Carries NUM_DATA data channels of DATA_W bits plus one CTRL_W control bundle.
- Adds a valid/ready handshake with an optional 2-entry skid buffer, so back-pressure never loses a beat and never needs a combinational ready path.
- Adds a synchronous flush that inserts a bubble by zeroing control and, optionally, data.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 tb/tb_pipe_stage_reg.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with NUM_DATA data channels plus a control bundle; 1-cycle latency.
// Backpressure: optional 2-entry skid with registered in_ready, else single entry with in_ready = ~out_valid | out_ready.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int NUM_DATA   = 7,
    parameter int CTRL_W     = 16,
    parameter bit SKID_EN    = 1'b1,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [1:0]                 occupancy
);

    localparam int DW = NUM_DATA * DATA_W;

    logic              main_vld;
    logic              skid_vld;
    logic              rdy_q;
    logic [1:0]        occ_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DW-1:0]     main_dat;
    logic [DW-1:0]     skid_dat;

    logic accept;
    logic advance;
    logic load_main;
    logic load_skid;
    logic nxt_main_vld;
    logic nxt_skid_vld;

    assign in_ready = SKID_EN ? rdy_q : (~main_vld | out_ready);
    assign accept   = in_valid & in_ready;
    // main is free to take a new beat this cycle when empty or draining
    assign advance  = ~main_vld | out_ready;

    always_comb begin
        nxt_main_vld = main_vld;
        nxt_skid_vld = skid_vld;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        if (flush) begin
            nxt_main_vld = 1'b0;
            nxt_skid_vld = 1'b0;
        end else if (advance) begin
            nxt_main_vld = skid_vld | accept;
            nxt_skid_vld = skid_vld & accept;
            load_main    = skid_vld | accept;
            load_skid    = skid_vld & accept;
        end else if (accept) begin
            nxt_skid_vld = 1'b1;
            load_skid    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            rdy_q     <= 1'b1;
            occ_q     <= 2'd0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_dat  <= '0;
            skid_dat  <= '0;
        end else begin
            main_vld <= nxt_main_vld;
            skid_vld <= nxt_skid_vld;
            rdy_q    <= ~nxt_skid_vld;
            occ_q    <= {1'b0, nxt_main_vld} + {1'b0, nxt_skid_vld};
            if (flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
                if (CLEAR_DATA) begin
                    main_dat <= '0;
                    skid_dat <= '0;
                end
            end else begin
                if (load_main) begin
                    main_ctrl <= skid_vld ? skid_ctrl : in_ctrl;
                    main_dat  <= skid_vld ? skid_dat  : in_data;
                end else if (advance) begin
                    // main turns into a bubble: its control must not fire downstream
                    main_ctrl <= '0;
                end
                if (load_skid) begin
                    skid_ctrl <= in_ctrl;
                    skid_dat  <= in_data;
                end
            end
        end
    end

    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_ctrl : '0;
    assign out_data  = main_dat;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid build, single-entry build and a 3x64 wide build against a queue model.
module tb_pipe_stage_reg;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // skid build (defaults)
    logic         m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [15:0]  m_in_ctrl, m_out_ctrl;
    logic [223:0] m_in_data, m_out_data;
    logic [1:0]   m_occ;

    // single-entry build
    logic         n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [15:0]  n_in_ctrl, n_out_ctrl;
    logic [223:0] n_in_data, n_out_data;
    logic [1:0]   n_occ;

    // wide build
    logic         w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [15:0]  w_in_ctrl, w_out_ctrl;
    logic [191:0] w_in_data, w_out_data;
    logic [1:0]   w_occ;

    pipe_stage_reg u_dut (
        .clk(clk), .rstn(rstn), .flush(m_flush),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_ctrl(m_in_ctrl), .in_data(m_in_data),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_ctrl(m_out_ctrl), .out_data(m_out_data),
        .occupancy(m_occ)
    );

    pipe_stage_reg #(.SKID_EN(1'b0)) u_ns (
        .clk(clk), .rstn(rstn), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_ctrl(n_in_ctrl), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .occupancy(n_occ)
    );

    pipe_stage_reg #(.NUM_DATA(3), .DATA_W(64)) u_wide (
        .clk(clk), .rstn(rstn), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_ctrl(w_in_ctrl), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_ctrl(w_out_ctrl), .out_data(w_out_data),
        .occupancy(w_occ)
    );

    // Reference: each stage is an ordered queue of {ctrl,data} beats, capacity 2 (skid) or 1.
    logic [239:0] mq[$];
    logic [239:0] nq[$];
    bit m_dz = 1'b1;
    bit n_dz = 1'b1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [223:0] rand224();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_m(input bit v, input logic [15:0] c, input logic [31:0] ch0);
        m_in_valid = v;
        m_in_ctrl  = c;
        m_in_data  = rand224();
        m_in_data[31:0] = ch0;
    endtask

    task automatic model_step();
        bit acc, drn;
        if (!rstn) begin
            mq.delete(); nq.delete();
            m_dz = 1'b1; n_dz = 1'b1;
            return;
        end
        acc = m_in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && m_out_ready;
        if (m_flush) begin
            mq.delete(); m_dz = 1'b1;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin mq.push_back({m_in_ctrl, m_in_data}); m_dz = 1'b0; end
        end
        acc = n_in_valid && ((nq.size() == 0) || n_out_ready);
        drn = (nq.size() > 0) && n_out_ready;
        if (n_flush) begin
            nq.delete(); n_dz = 1'b1;
        end else begin
            if (drn) void'(nq.pop_front());
            if (acc) begin nq.push_back({n_in_ctrl, n_in_data}); n_dz = 1'b0; end
        end
    endtask

    task automatic check_regs();
        logic [239:0] h;
        chk("m_valid", 256'(m_out_valid), 256'(mq.size() > 0));
        chk("m_occ", 256'(m_occ), 256'(mq.size()));
        chk("m_in_ready", 256'(m_in_ready), 256'(mq.size() < 2));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("m_ctrl", 256'(m_out_ctrl), 256'(h[239:224]));
            chk("m_data", 256'(m_out_data), 256'(h[223:0]));
        end else begin
            chk("m_bubble_ctrl", 256'(m_out_ctrl), 256'(0));
            if (m_dz) chk("m_zero_data", 256'(m_out_data), 256'(0));
        end
        chk("n_valid", 256'(n_out_valid), 256'(nq.size() > 0));
        chk("n_occ", 256'(n_occ), 256'(nq.size()));
        if (nq.size() > 0) begin
            h = nq[0];
            chk("n_ctrl", 256'(n_out_ctrl), 256'(h[239:224]));
            chk("n_data", 256'(n_out_data), 256'(h[223:0]));
        end else begin
            chk("n_bubble_ctrl", 256'(n_out_ctrl), 256'(0));
            if (n_dz) chk("n_zero_data", 256'(n_out_data), 256'(0));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("n_in_ready_comb", 256'(n_in_ready), 256'((nq.size() == 0) || n_out_ready));
        @(posedge clk);
        model_step();
        #1;
        check_regs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [223:0] saved;
        logic [63:0]  w0, w1;
        m_flush = 0; m_in_valid = 0; m_out_ready = 0; m_in_ctrl = 0; m_in_data = 0;
        n_flush = 0; n_in_valid = 0; n_out_ready = 0; n_in_ctrl = 0; n_in_data = 0;
        w_flush = 0; w_in_valid = 0; w_out_ready = 0; w_in_ctrl = 0; w_in_data = 0;

        // reset state
        tick();
        tick();
        chk("rst_m_in_ready", 256'(m_in_ready), 256'(1));
        chk("rst_m_occ", 256'(m_occ), 256'(0));
        chk("rst_w_valid", 256'(w_out_valid), 256'(0));
        chk("rst_w_data", 256'(w_out_data), 256'(0));
        rstn = 1'b1;

        // streaming with out_ready high
        m_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            drive_m(1, 16'h0100 + 16'(i), 32'h1000 + 32'(4 * i));
            tick();
            chk("t1_ch0", 256'(m_out_data[31:0]), 256'(32'h1000 + 32'(4 * i)));
            chk("t1_occ", 256'(m_occ), 256'(1));
            chk("t1_in_ready", 256'(m_in_ready), 256'(1));
        end
        drive_m(0, 16'h0, 32'h0);
        tick();

        // stall fills the skid, then drain in order
        m_out_ready = 0;
        drive_m(1, 16'h00AA, 32'hA); tick();
        drive_m(1, 16'h00BB, 32'hB); tick();
        chk("t2_occ_full", 256'(m_occ), 256'(2));
        chk("t2_ready_low", 256'(m_in_ready), 256'(0));
        chk("t2_head_a", 256'(m_out_data[31:0]), 256'(32'hA));
        drive_m(0, 16'h0, 32'h0); tick();
        chk("t2_head_stable", 256'(m_out_data[31:0]), 256'(32'hA));
        m_out_ready = 1; tick();
        chk("t2_then_b", 256'(m_out_data[31:0]), 256'(32'hB));
        tick();
        chk("t2_empty", 256'(m_out_valid), 256'(0));

        // flush with a full stage and an incoming beat
        m_out_ready = 0;
        drive_m(1, 16'h0C0C, 32'hC); tick();
        drive_m(1, 16'h0D0D, 32'hD); tick();
        m_flush = 1;
        drive_m(1, 16'hFFFF, 32'hE); tick();
        chk("t3_valid", 256'(m_out_valid), 256'(0));
        chk("t3_ctrl", 256'(m_out_ctrl), 256'(0));
        chk("t3_occ", 256'(m_occ), 256'(0));
        chk("t3_data", 256'(m_out_data), 256'(0));
        chk("t3_ready", 256'(m_in_ready), 256'(1));
        m_flush = 0; m_out_ready = 1;
        drive_m(0, 16'h0, 32'h0); tick();
        chk("t3_dropped", 256'(m_out_valid), 256'(0));

        // asynchronous reset between edges
        drive_m(1, 16'h5555, 32'h55); tick();
        drive_m(1, 16'h6666, 32'h66);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("t4_async_valid", 256'(m_out_valid), 256'(0));
        chk("t4_async_ctrl", 256'(m_out_ctrl), 256'(0));
        chk("t4_async_data", 256'(m_out_data), 256'(0));
        chk("t4_async_occ", 256'(m_occ), 256'(0));
        chk("t4_async_ready", 256'(m_in_ready), 256'(1));
        mq.delete(); nq.delete(); m_dz = 1'b1; n_dz = 1'b1;
        drive_m(0, 16'h0, 32'h0);
        tick();
        rstn = 1'b1;
        drive_m(1, 16'h1234, 32'h77);
        saved = m_in_data;
        tick();
        chk("t4_first_data", 256'(m_out_data), 256'(saved));
        chk("t4_first_ctrl", 256'(m_out_ctrl), 256'(16'h1234));
        drive_m(0, 16'h0, 32'h0); tick();

        // random traffic on both builds
        for (int i = 0; i < 1000; i++) begin
            m_in_valid  = 1'($urandom_range(0, 1));
            m_out_ready = 1'($urandom_range(0, 1));
            m_in_ctrl   = 16'($urandom);
            m_in_data   = rand224();
            m_flush     = ($urandom_range(0, 31) == 0);
            n_in_valid  = 1'($urandom_range(0, 1));
            n_out_ready = 1'($urandom_range(0, 1));
            n_in_ctrl   = 16'($urandom);
            n_in_data   = rand224();
            n_flush     = ($urandom_range(0, 31) == 0);
            tick();
            chk("t5_n_occ_max", 256'(n_occ <= 2'd1), 256'(1));
        end
        m_flush = 0; n_flush = 0; m_in_valid = 0; n_in_valid = 0;
        m_out_ready = 1; n_out_ready = 1;
        repeat (3) tick();

        // wide build: channel 2 lands on bits [191:128]
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        w_in_data  = {64'hDEAD_BEEF_0123_4567, w1, w0};
        w_in_ctrl  = 16'h00A5;
        w_in_valid = 1; w_out_ready = 1;
        tick();
        chk("t6_valid", 256'(w_out_valid), 256'(1));
        chk("t6_ch2", 256'(w_out_data[191:128]), 256'(64'hDEAD_BEEF_0123_4567));
        chk("t6_ch1", 256'(w_out_data[127:64]), 256'(w1));
        chk("t6_ch0", 256'(w_out_data[63:0]), 256'(w0));
        chk("t6_ctrl", 256'(w_out_ctrl), 256'(16'h00A5));
        w_in_valid = 0;
        tick();
        chk("t6_drained", 256'(w_out_valid), 256'(0));
        chk("t6_drained_ctrl", 256'(w_out_ctrl), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
